// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: 17-bit dividend by 9-bit divisor,
// restoring iteration on magnitudes with truncating sign fix-up.
module seq_signed_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] dividend,
  input  logic [8:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] quotient,
  output logic [8:0]  remainder,
  output logic        div_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [16:0] dvd_q, dvd_d;
  logic [8:0]  dvs_q, dvs_d;
  logic [8:0]  rem_q, rem_d;
  logic [16:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgq_q, sgq_d;
  logic        sgr_q, sgr_d;
  logic [16:0] quotient_q, quotient_d;
  logic [8:0]  remainder_q, remainder_d;
  logic        div_zero_q, div_zero_d;
  logic        overflow_q, overflow_d;
  logic [9:0]  trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      sgq_q       <= 1'b0;
      sgr_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      sgq_q       <= sgq_d;
      sgr_q       <= sgr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    sgq_d       = sgq_q;
    sgr_d       = sgr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;
    // Partial remainder stays below |divisor| <= 256, so bit 8 is 0.
    trial       = {rem_q, dvd_q[16]} - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == 9'd0) begin
            div_zero_d  = 1'b1;
            overflow_d  = 1'b0;
            quotient_d  = '0;
            remainder_d = '0;
            state_d     = DONE;
          end else begin
            dvd_d   = dividend[16] ? -dividend : dividend;
            dvs_d   = divisor[8] ? -divisor : divisor;
            sgq_d   = dividend[16] ^ divisor[8];
            sgr_d   = dividend[16];
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = 5'd16;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        dvd_d = {dvd_q[15:0], 1'b0};
        if (!trial[9]) begin
          rem_d = trial[8:0];
          quo_d = {quo_q[15:0], 1'b1};
        end else begin
          rem_d = {rem_q[7:0], dvd_q[16]};
          quo_d = {quo_q[15:0], 1'b0};
        end
        if (cnt_q == 5'd0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      FIX: begin
        div_zero_d = 1'b0;
        // Only -65536 / -1 yields a positive magnitude of 65536.
        if (!sgq_q && quo_q[16]) begin
          overflow_d  = 1'b1;
          quotient_d  = 17'h0FFFF;
          remainder_d = '0;
        end else begin
          overflow_d  = 1'b0;
          quotient_d  = sgq_q ? -quo_q : quo_q;
          remainder_d = sgr_q ? -rem_q : rem_q;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: vector table, corner sequences
// and randomized operands against an integer-arithmetic model.
module tb_seq_signed_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] dividend;
  logic [8:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] quotient;
  logic [8:0]  remainder;
  logic        div_zero;
  logic        overflow;

  int n_cmp;
  int n_bad;

  seq_signed_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          a;
    int          b;
    logic [16:0] q;
    logic [8:0]  r;
    logic        dz;
    logic        ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Truncating division as SystemVerilog int arithmetic defines it.
  task automatic model(input int a, input int b,
                       output logic [16:0] q, output logic [8:0] r,
                       output logic dz, output logic ov);
    int qi;
    int ri;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      dz = 1'b1;
      q  = '0;
      r  = '0;
    end else begin
      qi = a / b;
      ri = a % b;
      if (qi > 65535) begin
        ov = 1'b1;
        q  = 17'h0FFFF;
        r  = '0;
      end else begin
        q = 17'(qi);
        r = 9'(ri);
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
  endtask

  // Issue one operand pair; lat counts cycles from the accept
  // cycle (inclusive) up to the first cycle out_valid is seen.
  task automatic start_op(input int a, input int b, output bit ok);
    wait_ready(ok);
    if (!ok) begin
      chk("ready_timeout", 0, 1);
    end else begin
      dividend = 17'(a);
      divisor  = 9'(b);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_result(output int lat, output bit got);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1'b1;
    end
    if (!got) chk("valid_timeout", 0, 1);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input int a, input int b,
                           input bit chk_lat);
    logic [16:0] eq;
    logic [8:0]  er;
    logic        edz;
    logic        eov;
    bit          ok;
    bit          got;
    int          lat;
    model(a, b, eq, er, edz, eov);
    start_op(a, b, ok);
    if (ok) begin
      wait_result(lat, got);
      if (got) begin
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_dz"}, 32'(div_zero), 32'(edz));
        chk({tag, "_ov"}, 32'(overflow), 32'(eov));
        if (chk_lat) chk({tag, "_lat"}, lat, (b == 0) ? 1 : 19);
        consume();
      end
    end
  endtask

  vec_t vt[12];
  logic [16:0] hq;
  logic [8:0]  hr;
  bit          ok;
  bit          got;
  int          lat;
  int          ra;
  int          rb;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    vt[0]  = '{1000, -7, 17'(-142), 9'(6), 0, 0};
    vt[1]  = '{-100, 7, 17'(-14), 9'(-2), 0, 0};
    vt[2]  = '{-65536, -256, 17'(256), 9'(0), 0, 0};
    vt[3]  = '{-65536, -1, 17'h0FFFF, 9'(0), 0, 1};
    vt[4]  = '{5, 0, 17'(0), 9'(0), 1, 0};
    vt[5]  = '{12, 4, 17'(3), 9'(0), 0, 0};
    vt[6]  = '{65535, 1, 17'(65535), 9'(0), 0, 0};
    vt[7]  = '{-65536, 1, 17'h10000, 9'(0), 0, 0};
    vt[8]  = '{65535, -256, 17'(-255), 9'(255), 0, 0};
    vt[9]  = '{-1, 255, 17'(0), 9'(-1), 0, 0};
    vt[10] = '{7, -256, 17'(0), 9'(7), 0, 0};
    vt[11] = '{-12345, 0, 17'(0), 9'(0), 1, 0};

    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_q", 32'(quotient), 0);
    chk("rst_r", 32'(remainder), 0);
    chk("rst_dz", 32'(div_zero), 0);
    chk("rst_ov", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 1);

    for (int i = 0; i < 12; i++) begin
      start_op(vt[i].a, vt[i].b, ok);
      if (ok) begin
        wait_result(lat, got);
        if (got) begin
          chk($sformatf("vec%0d_q", i), 32'(quotient), 32'(vt[i].q));
          chk($sformatf("vec%0d_r", i), 32'(remainder), 32'(vt[i].r));
          chk($sformatf("vec%0d_dz", i), 32'(div_zero), 32'(vt[i].dz));
          chk($sformatf("vec%0d_ov", i), 32'(overflow), 32'(vt[i].ov));
          chk($sformatf("vec%0d_lat", i), lat,
              (vt[i].b == 0) ? 1 : 19);
          consume();
        end
      end
    end

    // Stall in DONE while offering new operands.
    start_op(1000, -7, ok);
    wait_result(lat, got);
    hq = 17'(-142);
    hr = 9'(6);
    dividend = 17'(99);
    divisor  = 9'(3);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_ready", 32'(in_ready), 0);
      chk("stall_q", 32'(quotient), 32'(hq));
      chk("stall_r", 32'(remainder), 32'(hr));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 0);
    chk("release_ready", 32'(in_ready), 1);
    chk("retain_q", 32'(quotient), 32'(hq));
    chk("retain_r", 32'(remainder), 32'(hr));
    repeat (3) @(negedge clk);
    chk("noqueue_ready", 32'(in_ready), 1);

    // Reset during iteration aborts the operation.
    start_op(30000, 77, ok);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_q", 32'(quotient), 0);
    chk("abort_r", 32'(remainder), 0);
    chk("abort_dz", 32'(div_zero), 0);
    chk("abort_ov", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    chk("abort_no_result", 32'(got), 0);
    run_check("post_abort", 12, 4, 1'b1);

    for (int i = 0; i < 200; i++) begin
      ra = int'($signed(17'($urandom)));
      case ($urandom_range(0, 7))
        0: rb = 0;
        1: rb = -1;
        2: rb = 1;
        3: rb = -256;
        default: rb = int'($signed(9'($urandom)));
      endcase
      if ($urandom_range(0, 9) == 0) ra = -65536;
      run_check($sformatf("rnd%0d", i), ra, rb, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
